term_stream_ctrl: RTL

TERM_STREAM_CTRL -- requirements
Module: term_stream_ctrl

---
 rtl/term_stream_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/term_stream_ctrl.sv
// Issue/capture controller for a fixed-latency FP term pipeline with a
// credit-limited result FIFO that decouples capture from downstream pops.
//
// Ports:
//   clk, reset         - single clock, async active-high reset
//   clk_en             - global enable shared with the pipeline
//   in_valid/in_ready  - upstream sample handshake, in_data is sample x
//   pipe_x/pipe_en     - pipeline drive (pass-through of in_data/clk_en)
//   pipe_result        - pipeline result q
//   out_valid/ready    - downstream handshake, out_data is FIFO head
//   inflight           - issued samples not yet captured
module term_stream_ctrl #(
    parameter int LATENCY = 24,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] pipe_x,
    output logic        pipe_en,
    input  logic [31:0] pipe_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [6:0]  inflight
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LATENCY:1] tag;
    logic [LATENCY:0] tag_sh;
    logic [31:0]      mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [7:0]       credit;
    logic [31:0]      head_next;
    logic             accept;
    logic             capture;
    logic             pop;

    assign pipe_x  = in_data;
    assign pipe_en = clk_en;

    // Captured + in-flight results can never exceed the FIFO size, so a
    // capture always finds a free slot.
    assign credit   = 8'(count) + 8'(inflight);
    assign in_ready = clk_en & ~reset & (credit < 8'(DEPTH));
    assign accept   = in_valid & in_ready;

    assign capture = clk_en & tag[LATENCY];
    assign pop     = out_valid & out_ready;

    // Shift in the accept flag; the top bit falls off the end.
    assign tag_sh = {tag, accept};

    assign rd_next    = rd_ptr + PW'(pop);
    assign count_next = count + CW'(capture) - CW'(pop);

    // Head register is refilled from the write data when the new head is
    // the very slot being written this edge (FIFO otherwise empty).
    always_comb begin
        head_next = mem[rd_next];
        if (capture && (wr_ptr == rd_next))
            head_next = pipe_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag      <= '0;
            inflight <= '0;
        end else if (clk_en) begin
            tag <= tag_sh[LATENCY-1:0];
            if (accept && !capture)
                inflight <= inflight + 7'd1;
            else if (!accept && capture)
                inflight <= inflight - 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            mem[wr_ptr] <= pipe_result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (capture)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr    <= rd_next;
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (capture || pop)
                out_data <= head_next;
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (reset)
        !(capture && (count == CW'(DEPTH)) && !pop)
    );

endmodule
